// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: unpack, iterative align, one
// signed-magnitude add, iterative normalise, pack. Truncating, denormals flushed.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The sequencer holds o_valid/o_result/flags stable until i_ready is seen,
// and o_ready is high only while IDLE.

module complement_adder (
  input  logic        sign1,
  input  logic        sign2,
  input  logic [23:0] i_add1,
  input  logic [23:0] i_add2,
  output logic [23:0] oo_result,
  output logic        o_carry,
  output logic        shift_flag
);
  logic [24:0] sum25;
  logic [23:0] pos_m;
  logic [23:0] neg_m;

  always_comb begin
    sum25      = '0;
    pos_m      = sign1 ? i_add2 : i_add1;
    neg_m      = sign1 ? i_add1 : i_add2;
    oo_result  = '0;
    o_carry    = 1'b0;
    shift_flag = 1'b0;
    if (sign1 == sign2) begin
      sum25      = {1'b0, i_add1} + {1'b0, i_add2};
      oo_result  = sum25[23:0];
      o_carry    = sum25[24];
      shift_flag = sum25[24];
    end else begin
      // carry out of pos + ~neg + 1 means pos >= neg, i.e. a non-negative result
      sum25     = {1'b0, pos_m} + {1'b0, ~neg_m} + 25'd1;
      o_carry   = sum25[24];
      oo_result = sum25[24] ? sum25[23:0] : (~sum25[23:0] + 24'd1);
    end
  end
endmodule

module fp_add_sequencer #(
  parameter int ALIGN_STEP = 1,
  parameter int NORM_STEP  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_busy,
  output logic [2:0]  o_state
);
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  localparam logic [7:0] ASTEP = 8'(ALIGN_STEP);
  localparam logic [7:0] NSTEP = 8'(NORM_STEP);

  state_t      state, nxt_state;
  logic        sign_a, sign_b, n_sign_a, n_sign_b;
  logic [7:0]  exp_a, n_exp_a, diff, n_diff, res_exp, n_res_exp;
  logic [23:0] mant_a, mant_b, n_mant_a, n_mant_b, sum_r, n_sum;
  logic        shift_r, n_shift, res_sign, n_res_sign;
  logic [31:0] n_result;
  logic        n_ovf, n_unf;

  logic [7:0]  e1, e2, udiff, a_amt, lz8, n_amt;
  logic        swap;
  logic [23:0] al_mant;
  logic [23:0] ca_res;
  logic        ca_carry, ca_shift;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  complement_adder u_add (
    .sign1     (sign_a),
    .sign2     (sign_b),
    .i_add1    (mant_a),
    .i_add2    (mant_b),
    .oo_result (ca_res),
    .o_carry   (ca_carry),
    .shift_flag(ca_shift)
  );

  assign e1      = i_op1[30:23];
  assign e2      = i_op2[30:23];
  assign swap    = e2 > e1;
  assign udiff   = swap ? (e2 - e1) : (e1 - e2);
  assign a_amt   = (diff < ASTEP) ? diff : ASTEP;
  assign al_mant = mant_b >> a_amt;
  assign lz8     = {3'b000, lzc24(sum_r)};
  assign n_amt   = (lz8 < NSTEP) ? lz8 : NSTEP;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    n_sign_a   = sign_a;
    n_sign_b   = sign_b;
    n_exp_a    = exp_a;
    n_mant_a   = mant_a;
    n_mant_b   = mant_b;
    n_diff     = diff;
    n_sum      = sum_r;
    n_shift    = shift_r;
    n_res_sign = res_sign;
    n_res_exp  = res_exp;
    n_result   = o_result;
    n_ovf      = o_overflow;
    n_unf      = o_underflow;
    case (state)
      S_IDLE: if (i_valid) begin
        n_sign_a = swap ? i_op2[31] : i_op1[31];
        n_sign_b = swap ? i_op1[31] : i_op2[31];
        n_exp_a  = swap ? e2 : e1;
        n_mant_a = swap ? {1'b1, i_op2[22:0]} : {1'b1, i_op1[22:0]};
        n_mant_b = swap ? {1'b1, i_op1[22:0]} : {1'b1, i_op2[22:0]};
        n_diff   = udiff;
        n_ovf    = 1'b0;
        n_unf    = 1'b0;
        nxt_state = S_DONE;
        if (e1 == 8'hFF)                n_result = i_op1;
        else if (e2 == 8'hFF)           n_result = i_op2;
        else if (e1 == 8'd0 && e2 == 8'd0) n_result = 32'd0;
        else if (e1 == 8'd0)            n_result = i_op2;
        else if (e2 == 8'd0)            n_result = i_op1;
        else if (udiff >= 8'd24)        n_result = swap ? i_op2 : i_op1;
        else if (udiff == 8'd0)         nxt_state = S_ADD;
        else                            nxt_state = S_ALIGN;
      end
      S_ALIGN: begin
        n_mant_b = al_mant;
        n_diff   = diff - a_amt;
        if (al_mant == 24'd0) begin
          n_result  = {sign_a, exp_a, mant_a[22:0]};
          nxt_state = S_DONE;
        end else if (diff == a_amt) begin
          nxt_state = S_ADD;
        end
      end
      S_ADD: begin
        n_sum      = ca_res;
        n_shift    = ca_shift;
        n_res_exp  = exp_a;
        n_res_sign = (sign_a == sign_b) ? sign_a : ~ca_carry;
        nxt_state  = S_NORM;
      end
      S_NORM: begin
        if (shift_r) begin
          n_shift   = 1'b0;
          nxt_state = S_DONE;
          if (res_exp == 8'd254) begin
            n_result = {res_sign, 8'hFF, 23'd0};
            n_ovf    = 1'b1;
          end else begin
            n_result = {res_sign, res_exp + 8'd1, sum_r[23:1]};
          end
        end else if (sum_r == 24'd0) begin
          n_result  = 32'd0;
          nxt_state = S_DONE;
        end else if (sum_r[23]) begin
          n_result  = {res_sign, res_exp, sum_r[22:0]};
          nxt_state = S_DONE;
        end else if (res_exp <= n_amt) begin
          n_result  = {res_sign, 31'd0};
          n_unf     = 1'b1;
          nxt_state = S_DONE;
        end else begin
          n_sum     = sum_r << n_amt;
          n_res_exp = res_exp - n_amt;
        end
      end
      S_DONE: if (i_ready) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sign_a <= 1'b0; sign_b <= 1'b0; exp_a <= '0; diff <= '0;
      mant_a <= '0; mant_b <= '0; sum_r <= '0; shift_r <= 1'b0;
      res_sign <= 1'b0; res_exp <= '0;
      o_result <= '0; o_overflow <= 1'b0; o_underflow <= 1'b0;
    end else begin
      sign_a <= n_sign_a; sign_b <= n_sign_b; exp_a <= n_exp_a; diff <= n_diff;
      mant_a <= n_mant_a; mant_b <= n_mant_b; sum_r <= n_sum; shift_r <= n_shift;
      res_sign <= n_res_sign; res_exp <= n_res_exp;
      o_result <= n_result; o_overflow <= n_ovf; o_underflow <= n_unf;
    end
  end

  always_comb begin
    o_ready = (state == S_IDLE);
    o_busy  = (state != S_IDLE);
    o_valid = (state == S_DONE);
    o_state = state;
  end
endmodule
